// File: rtl/acq_sequencer_if.sv
// Control/status bundle between the acquisition sequencer and the ADC, AGC and FIFO blocks.
// master is the sequencer's view; slave is the surrounding logic's view.
interface acq_sequencer_if;
    logic        start;
    logic        stop;
    logic        agc_req;
    logic [11:0] agc_req_data;
    logic [1:0]  adc_mbusy;
    logic        fifo_full;
    logic        adc_ldctrl;
    logic [9:0]  adc_ctrlword;
    logic        adc_enable;
    logic        agc_load;
    logic [11:0] agc_data;
    logic        running;
    logic        overflow;
    logic [2:0]  state;

    modport master (
        input  start, stop, agc_req, agc_req_data, adc_mbusy, fifo_full,
        output adc_ldctrl, adc_ctrlword, adc_enable, agc_load, agc_data, running, overflow, state
    );

    modport slave (
        output start, stop, agc_req, agc_req_data, adc_mbusy, fifo_full,
        input  adc_ldctrl, adc_ctrlword, adc_enable, agc_load, agc_data, running, overflow, state
    );
endinterface

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: configures both ADC channels, loads the initial AGC code, runs
// acquisition, rate-limits run-time AGC updates and stops on FIFO overflow.
module acq_sequencer #(
    parameter int unsigned CFG_DELAY    = 100,
    parameter int unsigned SETTLE_DELAY = 900,
    parameter logic [9:0]  CTRLWORD     = 10'b0000100100,
    parameter logic [11:0] AGC_INIT     = 12'h333,
    parameter int unsigned AGC_HOLDOFF  = 40,
    parameter bit          AUTO_START   = 1'b1,
    parameter bit          AUTO_RESTART = 1'b0
) (
    input logic              clk,
    input logic              arstn,
    acq_sequencer_if.master  bus
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StCfgWait = 3'd1;
    localparam logic [2:0] StLdWait  = 3'd2;
    localparam logic [2:0] StRun     = 3'd3;

    logic [2:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] hold_q, hold_d;
    logic        auto_q, auto_d;
    logic        ldctrl_q, ldctrl_d;
    logic        enable_q, enable_d;
    logic        load_q, load_d;
    logic [11:0] data_q, data_d;
    logic        running_q, running_d;
    logic        overflow_q, overflow_d;
    logic        pend_q, pend_d;
    logic [11:0] pend_val_q, pend_val_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = (&cnt_q) ? cnt_q : cnt_q + 32'd1;
        hold_d     = (hold_q != 32'd0) ? hold_q - 32'd1 : 32'd0;
        auto_d     = 1'b0;
        ldctrl_d   = 1'b0;
        load_d     = 1'b0;
        enable_d   = enable_q;
        data_d     = data_q;
        running_d  = running_q;
        overflow_d = overflow_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;

        unique case (state_q)
            StIdle: begin
                if (!bus.stop && (bus.start || auto_q)) begin
                    state_d    = StCfgWait;
                    cnt_d      = '0;
                    overflow_d = 1'b0;
                    data_d     = AGC_INIT;
                end
            end
            StCfgWait: begin
                if (bus.stop) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CFG_DELAY - 1) begin
                    ldctrl_d = 1'b1;
                    state_d  = StLdWait;
                    cnt_d    = '0;
                end
            end
            StLdWait: begin
                if (bus.stop) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q >= SETTLE_DELAY - 1 && bus.adc_mbusy == 2'b00) begin
                    load_d    = 1'b1;
                    enable_d  = 1'b1;
                    running_d = 1'b1;
                    hold_d    = AGC_HOLDOFF - 1;
                    state_d   = StRun;
                    cnt_d     = '0;
                end
            end
            StRun: begin
                if (bus.stop || bus.fifo_full) begin
                    enable_d  = 1'b0;
                    running_d = 1'b0;
                    pend_d    = 1'b0;
                    cnt_d     = '0;
                    state_d   = StIdle;
                    if (!bus.stop) begin
                        overflow_d = 1'b1;
                        if (AUTO_RESTART) begin
                            state_d = StCfgWait;
                            data_d  = AGC_INIT;
                        end
                    end
                end else begin
                    // Service the older pending code first; a same-cycle request becomes pending.
                    if (pend_q && hold_q == 32'd0) begin
                        load_d = 1'b1;
                        data_d = pend_val_q;
                        pend_d = 1'b0;
                        hold_d = AGC_HOLDOFF - 1;
                    end
                    if (bus.agc_req) begin
                        pend_d     = 1'b1;
                        pend_val_d = bus.agc_req_data;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            hold_q     <= '0;
            auto_q     <= AUTO_START;
            ldctrl_q   <= 1'b0;
            enable_q   <= 1'b0;
            load_q     <= 1'b0;
            data_q     <= AGC_INIT;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            auto_q     <= auto_d;
            ldctrl_q   <= ldctrl_d;
            enable_q   <= enable_d;
            load_q     <= load_d;
            data_q     <= data_d;
            running_q  <= running_d;
            overflow_q <= overflow_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
        end
    end

    assign bus.adc_ldctrl   = ldctrl_q;
    assign bus.adc_ctrlword = CTRLWORD;
    assign bus.adc_enable   = enable_q;
    assign bus.agc_load     = load_q;
    assign bus.agc_data     = data_q;
    assign bus.running      = running_q;
    assign bus.overflow     = overflow_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Bench for acq_sequencer: timeline model (edge timestamps) checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_acq_sequencer;

    localparam int          CfgDelay    = 100;
    localparam int          SettleDelay = 900;
    localparam int          Holdoff     = 40;
    localparam logic [11:0] AgcInit     = 12'h333;
    localparam logic [9:0]  CtrlWord    = 10'b0000100100;

    logic clk   = 1'b0;
    logic arstn = 1'b0;
    always #5 clk = ~clk;

    acq_sequencer_if bus ();

    acq_sequencer #(
        .CFG_DELAY    (CfgDelay),
        .SETTLE_DELAY (SettleDelay),
        .CTRLWORD     (CtrlWord),
        .AGC_INIT     (AgcInit),
        .AGC_HOLDOFF  (Holdoff),
        .AUTO_START   (1'b1),
        .AUTO_RESTART (1'b0)
    ) dut (
        .clk   (clk),
        .arstn (arstn),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rel_edge = 0;

    // Model: phase 0..3 matches the published state numbering; timing from timestamps.
    int          m_ph, m_t0, m_last;
    bit          m_auto, m_fresh, m_pend, m_ovf, m_ld, m_load;
    logic [11:0] m_pval, m_data;

    int          ld_q[$];
    int          load_e[$];
    logic [11:0] load_v[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_auto = 1'b1; m_fresh = 1'b1; m_pend = 1'b0; m_ovf = 1'b0;
        m_ld = 1'b0; m_load = 1'b0; m_pval = '0; m_data = AgcInit; m_last = -1000000; m_t0 = 0;
    endtask

    task automatic model_step();
        m_ld   = 1'b0;
        m_load = 1'b0;
        if (m_fresh) begin
            rel_edge = cyc;
            m_fresh  = 1'b0;
        end
        case (m_ph)
            0: begin
                if ((bus.start || m_auto) && !bus.stop) begin
                    m_ph = 1; m_t0 = cyc; m_ovf = 1'b0; m_data = AgcInit;
                end
                m_auto = 1'b0;
            end
            1: begin
                if (bus.stop) m_ph = 0;
                else if (cyc - m_t0 == CfgDelay) begin
                    m_ld = 1'b1; m_ph = 2;
                end
            end
            2: begin
                if (bus.stop) m_ph = 0;
                else if (cyc - m_t0 >= CfgDelay + SettleDelay && bus.adc_mbusy == 2'b00) begin
                    m_load = 1'b1; m_last = cyc; m_ph = 3;
                end
            end
            default: begin
                if (bus.stop || bus.fifo_full) begin
                    if (!bus.stop) m_ovf = 1'b1;
                    m_ph = 0; m_pend = 1'b0;
                end else begin
                    if (m_pend && cyc - m_last >= Holdoff) begin
                        m_load = 1'b1; m_data = m_pval; m_pend = 1'b0; m_last = cyc;
                    end
                    if (bus.agc_req) begin
                        m_pend = 1'b1; m_pval = bus.agc_req_data;
                    end
                end
            end
        endcase
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge arstn);
            if (!arstn) model_reset();
            else begin
                cyc++;
                model_step();
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("state", {29'd0, bus.state}, m_ph);
            chk("adc_enable", bus.adc_enable, m_ph == 3);
            chk("running", bus.running, m_ph == 3);
            chk("overflow", bus.overflow, m_ovf);
            chk("adc_ldctrl", bus.adc_ldctrl, m_ld);
            chk("agc_load", bus.agc_load, m_load);
            chk("agc_data", bus.agc_data, m_data);
            chk("adc_ctrlword", bus.adc_ctrlword, CtrlWord);
            if (bus.adc_ldctrl === 1'b1) ld_q.push_back(cyc);
            if (bus.agc_load === 1'b1) begin
                load_e.push_back(cyc);
                load_v.push_back(bus.agc_data);
            end
        end
    end

    task automatic drive(input bit s, input bit sp, input bit rq, input logic [11:0] d,
                         input bit ff);
        bus.start = s; bus.stop = sp; bus.agc_req = rq; bus.agc_req_data = d; bus.fifo_full = ff;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
    endtask

    task automatic clear_logs();
        ld_q.delete();
        load_e.delete();
        load_v.delete();
    endtask

    initial begin
        int s;
        int r;
        bus.start = 1'b0; bus.stop = 1'b0; bus.agc_req = 1'b0; bus.agc_req_data = '0;
        bus.adc_mbusy = 2'b00; bus.fifo_full = 1'b0;

        // Reset values, then auto-start sequence.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_state", bus.state, 3'd0);
        chk("rst_agc_data", bus.agc_data, 12'h333);
        chk("rst_enable", bus.adc_enable, 1'b0);
        arstn = 1'b1;
        idle(1010);
        chk("auto_ld_count", ld_q.size(), 1);
        if (ld_q.size() > 0) chk("auto_ld_edge", ld_q[0] - rel_edge, 100);
        chk("auto_load_count", load_e.size(), 1);
        if (load_e.size() > 0) begin
            chk("auto_load_edge", load_e[0] - rel_edge, 1000);
            chk("auto_load_val", load_v[0], 12'h333);
        end
        chk("auto_running", bus.running, 1'b1);

        // Run-time AGC: last value wins, holdoff spacing.
        idle(40);
        clear_logs();
        drive(1'b0, 1'b0, 1'b1, 12'h400, 1'b0);
        r = cyc;
        idle(4);
        drive(1'b0, 1'b0, 1'b1, 12'h500, 1'b0);
        idle(9);
        drive(1'b0, 1'b0, 1'b1, 12'h600, 1'b0);
        idle(60);
        chk("agc_load_count", load_e.size(), 2);
        if (load_e.size() == 2) begin
            chk("agc_first_edge", load_e[0] - r, 1);
            chk("agc_first_val", load_v[0], 12'h400);
            chk("agc_second_edge", load_e[1] - r, 41);
            chk("agc_second_val", load_v[1], 12'h600);
        end

        // FIFO overflow stops acquisition on the next cycle.
        drive(1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
        chk("ovf_enable", bus.adc_enable, 1'b0);
        chk("ovf_flag", bus.overflow, 1'b1);
        chk("ovf_state", bus.state, 3'd0);
        idle(5);

        // start+stop together in IDLE stays IDLE.
        drive(1'b1, 1'b1, 1'b0, 12'h000, 1'b0);
        chk("startstop_state", bus.state, 3'd0);
        idle(3);

        // Stop during CFG_WAIT: no ldctrl; start clears overflow.
        clear_logs();
        drive(1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
        chk("restart_ovf_clear", bus.overflow, 1'b0);
        chk("restart_state", bus.state, 3'd1);
        idle(49);
        drive(1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
        chk("cfg_stop_state", bus.state, 3'd0);
        idle(200);
        chk("cfg_stop_no_ld", ld_q.size(), 0);
        chk("cfg_stop_no_load", load_e.size(), 0);

        // Control-word shift busy delays enable.
        clear_logs();
        bus.adc_mbusy = 2'b01;
        drive(1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
        s = cyc;
        idle(1500);
        bus.adc_mbusy = 2'b00;
        idle(10);
        chk("mbusy_load_count", load_e.size(), 1);
        if (load_e.size() > 0) chk("mbusy_load_edge", load_e[0] - s, 1501);
        chk("mbusy_enable", bus.adc_enable, 1'b1);

        // Async reset in RUN with a pending request.
        idle(50);
        drive(1'b0, 1'b0, 1'b1, 12'h123, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 12'h7ab, 1'b0);
        #1 arstn = 1'b0;
        #1;
        chk("arst_enable", bus.adc_enable, 1'b0);
        chk("arst_running", bus.running, 1'b0);
        chk("arst_state", bus.state, 3'd0);
        chk("arst_agc_data", bus.agc_data, 12'h333);
        chk("arst_load", bus.agc_load, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        clear_logs();
        arstn = 1'b1;
        idle(1010);
        chk("rearm_load_count", load_e.size(), 1);
        if (load_e.size() > 0) begin
            chk("rearm_load_edge", load_e[0] - rel_edge, 1000);
            chk("rearm_load_val", load_v[0], 12'h333);
        end

        // Randomized traffic against the model.
        clear_logs();
        for (int i = 0; i < 15000; i++) begin
            bus.adc_mbusy = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 2999) == 0,
                  $urandom_range(0, 5) == 0, 12'($urandom), $urandom_range(0, 2499) == 0);
        end
        for (int i = 1; i < load_e.size(); i++)
            chk("load_spacing", load_e[i] - load_e[i-1] >= Holdoff, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
